nios_system_tec2_cpu_cpu_ocimem_arbiter: RTL and testbench
==========================================================

NIOS_SYSTEM_TEC2_CPU_CPU_OCIMEM_ARBITER -- requirements
Module: nios_system_tec2_cpu_cpu_ocimem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 8, debug-RAM word-address width; DATA_W, default 32, data width.
REQ-002 SHALL have clock and reset ports: clk, input, 1 bit, the single clock; reset_n, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have ports: jdo, input, 38 bits, JTAG command payload, sampled only on strobes.
REQ-004 SHALL have ports: take_action_ocimem_a, input, 1 bit, one-cycle strobe; loads the address from jdo[ADDR_W+9:10]; jdo[35]=1 also requests a read.
REQ-005 SHALL have ports: take_action_ocimem_b, input, 1 bit, one-cycle strobe; writes jdo[34:3] at the current address, then increments the address.
REQ-006 SHALL have ports: take_no_action_ocimem_a, input, 1 bit, one-cycle strobe; reads at the current address, then increments the address.
REQ-007 SHALL have ports: debugack, input, 1 bit, CPU is in debug mode.
REQ-008 SHALL have ports: cpu_req, cpu_we, inputs, 1 bit each; cpu_addr, input, ADDR_W bits; cpu_wdata, input, DATA_W bits.
REQ-009 SHALL have ports: cpu_gnt, output, 1 bit; cpu_rvalid, output, 1 bit; cpu_rdata, output, DATA_W bits.
REQ-010 SHALL have ports: mem_addr, output, ADDR_W bits; mem_we, output, 1 bit; mem_re, output, 1 bit; mem_wdata, output, DATA_W bits; mem_rdata, input, DATA_W bits (synchronous RAM, 1-cycle read latency).
REQ-011 SHALL have ports: MonDReg, output, 32 bits; monitor_ready, output, 1 bit; monitor_error, output, 1 bit; jtag_busy, output, 1 bit.

Function
REQ-012 SHALL hold at most one pending JTAG command (type, address, data); jtag_busy=1 while a command is pending or in progress.
REQ-013 SHALL, on any ocimem strobe when jtag_busy=0 and debugack=1, accept the command, clear monitor_ready and clear monitor_error in the next cycle.
REQ-014 SHALL, on a strobe while jtag_busy=1 or debugack=0, drop the command and set monitor_error=1 (sticky until the next accepted command); the address SHALL be unchanged.
REQ-015 SHALL treat simultaneous strobes with priority ocimem_a > ocimem_b > no_action_ocimem_a; lower-priority strobes in the same cycle SHALL be ignored without error.
REQ-016 SHALL implement FSM states: IDLE, GRANT_CPU, GRANT_JTAG, RD_WAIT.
REQ-017 SHALL move IDLE -> GRANT_JTAG or GRANT_CPU when requests exist; with both pending, SHALL round-robin using a last_winner flag (reset value selects JTAG first).
REQ-018 GRANT_CPU SHALL last one cycle: cpu_gnt=1 and mem_* driven from the cpu_* inputs; a read SHALL assert cpu_rvalid=1 with cpu_rdata=mem_rdata exactly one cycle after cpu_gnt.
REQ-019 GRANT_JTAG for a write SHALL assert mem_we for one cycle, set monitor_ready=1 the next cycle, and return to IDLE.
REQ-020 GRANT_JTAG for a read SHALL assert mem_re, then in RD_WAIT load MonDReg=mem_rdata and set monitor_ready=1 the following cycle.
REQ-021 Address increment SHALL wrap modulo 2^ADDR_W.
REQ-022 Worst-case JTAG latency from strobe to monitor_ready SHALL be at most 5 cycles under continuous cpu_req.
REQ-023 If debugack falls while a JTAG command is pending but not yet granted, the command SHALL be dropped and monitor_error SHALL be set.
REQ-024 mem_we and mem_re SHALL never be asserted in the same cycle; cpu_gnt SHALL be 0 outside GRANT_CPU.

Reset
REQ-025 On reset_n=0, asynchronously: FSM=IDLE, address=0, MonDReg=0, monitor_ready=0, monitor_error=0, jtag_busy=0, cpu_gnt=0, cpu_rvalid=0, mem_we=0, mem_re=0, last_winner=CPU.
REQ-026 Reset mid-access SHALL abort the access with no retry and no completion pulse after release.

Structure
REQ-027 The FSM state enum, the command-type enum (RD, WR) and the jdo bit-field positions SHALL live in a shared package nios_system_tec2_cpu_cpu_oci_pkg.
REQ-028 The one-deep command holding register SHALL be a sub-module, nios_system_tec2_cpu_cpu_ocimem_cmd_reg.

Verification
REQ-029 ocimem_a with jdo[17:10]=0x12 and jdo[35]=1, RAM[0x12]=0xCAFEF00D -> MonDReg=0xCAFEF00D and monitor_ready=1 within 4 cycles.
REQ-030 Address 0xFF, then ocimem_b with data 0x1 -> RAM[0xFF]=0x1 and address wraps to 0x00.
REQ-031 cpu_req held continuously plus a JTAG read -> alternating grants, monitor_ready=1 within 5 cycles.
REQ-032 Second strobe while jtag_busy=1 -> monitor_error=1 and the first command completes correctly.
REQ-033 Strobe with debugack=0 -> no mem access and monitor_error=1.
REQ-034 reset_n pulsed during RD_WAIT -> all outputs at reset values, and no monitor_ready after release.

Source files
------------

// File: rtl/nios_system_tec2_cpu_cpu_oci_pkg.sv
// Shared definitions for the OCI debug-memory arbiter.
// Holds the arbiter FSM state encoding, the JTAG command type, the
// round-robin winner encoding and the bit positions of fields inside the
// 38-bit JTAG payload (jdo).
package nios_system_tec2_cpu_cpu_oci_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StGrantCpu  = 2'd1,
    StGrantJtag = 2'd2,
    StRdWait    = 2'd3
  } arb_state_e;

  typedef enum logic {
    CmdRd = 1'b0,
    CmdWr = 1'b1
  } cmd_type_e;

  typedef enum logic {
    WinCpu  = 1'b0,
    WinJtag = 1'b1
  } winner_e;

  localparam int unsigned JdoWidth   = 38;
  localparam int unsigned JdoReadBit = 35;  // ocimem_a: also issue a read
  localparam int unsigned JdoDataLsb = 3;   // ocimem_b: write data jdo[34:3]
  localparam int unsigned JdoDataW   = 32;
  localparam int unsigned JdoAddrLsb = 10;  // ocimem_a: address jdo[ADDR_W+9:10]

endpackage

// File: rtl/nios_system_tec2_cpu_cpu_ocimem_cmd_reg.sv
// One-deep holding register for a pending JTAG debug-memory command.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   load                  capture load_type/load_addr/load_data, mark valid
//   clear                 drop the held command (granted or aborted)
//   valid                 a command is held
//   cmd_type/addr/data    the held command
module nios_system_tec2_cpu_cpu_ocimem_cmd_reg
  import nios_system_tec2_cpu_cpu_oci_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              clear,
  input  cmd_type_e         load_type,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output cmd_type_e         cmd_type,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data
);

  logic              valid_q;
  cmd_type_e         type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // Clear wins: a load is only ever offered while nothing is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      type_q  <= CmdRd;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      type_q  <= load_type;
      addr_q  <= load_addr;
      data_q  <= load_data;
    end
  end

  assign valid    = valid_q;
  assign cmd_type = type_q;
  assign cmd_addr = addr_q;
  assign cmd_data = data_q;

endmodule

// File: rtl/nios_system_tec2_cpu_cpu_ocimem_arbiter.sv
// Arbiter sharing one synchronous debug RAM between the CPU and JTAG.
// JTAG strobes decode jdo into a one-deep command; the FSM round-robins the
// RAM between that command and cpu_req.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   jdo, take_action_ocimem_a/b,
//   take_no_action_ocimem_a, debugack JTAG command interface
//   cpu_req/we/addr/wdata, cpu_gnt,
//   cpu_rvalid, cpu_rdata             CPU port (read data one cycle after grant)
//   mem_addr/we/re/wdata, mem_rdata   RAM port, 1-cycle read latency
//   MonDReg, monitor_ready,
//   monitor_error, jtag_busy          JTAG status / read-back
module nios_system_tec2_cpu_cpu_ocimem_arbiter
  import nios_system_tec2_cpu_cpu_oci_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [JdoWidth-1:0] jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic                take_no_action_ocimem_a,
  input  logic                debugack,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_gnt,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic                mem_re,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [31:0]         MonDReg,
  output logic                monitor_ready,
  output logic                monitor_error,
  output logic                jtag_busy
);

  arb_state_e        state_q, state_d;
  winner_e           last_winner_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cpu_rvalid_q;
  logic              monitor_ready_q;
  logic              monitor_error_q;
  logic [31:0]       mon_dreg_q;

  logic              strobe_any, accept, strobe_drop;
  logic              load_cmd;
  cmd_type_e         load_type;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [ADDR_W-1:0] jdo_addr;
  logic [JdoDataW-1:0] jdo_data;

  logic              cmd_valid, cmd_clear, pend_drop, jtag_req;
  cmd_type_e         cmd_type;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  logic              unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign jdo_addr = jdo[JdoAddrLsb +: ADDR_W];
  assign jdo_data = jdo[JdoDataLsb +: JdoDataW];

  assign jtag_busy   = cmd_valid | (state_q == StGrantJtag) | (state_q == StRdWait);
  assign strobe_any  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign accept      = strobe_any & ~jtag_busy & debugack;
  assign strobe_drop = strobe_any & (jtag_busy | ~debugack);

  // Strobe decode, priority a > b > no_action. A dropped strobe leaves the
  // address untouched. ocimem_a without the read bit only moves the address.
  always_comb begin
    load_cmd  = 1'b0;
    load_type = CmdRd;
    load_addr = addr_q;
    load_data = '0;
    addr_d    = addr_q;
    if (accept) begin
      if (take_action_ocimem_a) begin
        addr_d    = jdo_addr;
        load_addr = jdo_addr;
        load_cmd  = jdo[JdoReadBit];
      end else if (take_action_ocimem_b) begin
        load_cmd  = 1'b1;
        load_type = CmdWr;
        load_data = DATA_W'(jdo_data);
        addr_d    = addr_q + ADDR_W'(1);
      end else begin
        load_cmd  = 1'b1;
        addr_d    = addr_q + ADDR_W'(1);
      end
    end
  end

  // A held command loses debugack before being granted: abandon it.
  assign pend_drop = cmd_valid & ~debugack & (state_q != StGrantJtag);
  assign jtag_req  = cmd_valid & debugack & (state_q != StGrantJtag);
  assign cmd_clear = pend_drop | (state_q == StGrantJtag);

  nios_system_tec2_cpu_cpu_ocimem_cmd_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cmd_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load_cmd),
    .clear     (cmd_clear),
    .load_type (load_type),
    .load_addr (load_addr),
    .load_data (load_data),
    .valid     (cmd_valid),
    .cmd_type  (cmd_type),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; every access returns through StIdle for arbitration
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (jtag_req && cpu_req) begin
          state_d = (last_winner_q == WinCpu) ? StGrantJtag : StGrantCpu;
        end else if (jtag_req) begin
          state_d = StGrantJtag;
        end else if (cpu_req) begin
          state_d = StGrantCpu;
        end
      end
      StGrantCpu:  state_d = StIdle;
      StGrantJtag: state_d = (cmd_type == CmdRd) ? StRdWait : StIdle;
      StRdWait:    state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // FSM outputs: RAM port steering and CPU grant
  always_comb begin
    cpu_gnt   = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StGrantCpu: begin
        cpu_gnt   = 1'b1;
        mem_we    = cpu_we;
        mem_re    = ~cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      StGrantJtag: begin
        mem_we    = (cmd_type == CmdWr);
        mem_re    = (cmd_type == CmdRd);
        mem_addr  = cmd_addr;
        mem_wdata = cmd_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_winner_q <= WinCpu;
    end else if (state_q == StIdle) begin
      if (state_d == StGrantJtag) begin
        last_winner_q <= WinJtag;
      end else if (state_d == StGrantCpu) begin
        last_winner_q <= WinCpu;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q          <= '0;
      cpu_rvalid_q    <= 1'b0;
      monitor_ready_q <= 1'b0;
      monitor_error_q <= 1'b0;
      mon_dreg_q      <= '0;
    end else begin
      addr_q       <= addr_d;
      cpu_rvalid_q <= (state_q == StGrantCpu) & ~cpu_we;
      if (accept) begin
        monitor_ready_q <= 1'b0;
        monitor_error_q <= 1'b0;
      end else begin
        if (strobe_drop || pend_drop) begin
          monitor_error_q <= 1'b1;
        end
        if ((state_q == StGrantJtag) && (cmd_type == CmdWr)) begin
          monitor_ready_q <= 1'b1;
        end
        if (state_q == StRdWait) begin
          monitor_ready_q <= 1'b1;
          mon_dreg_q      <= 32'(mem_rdata);
        end
      end
    end
  end

  assign cpu_rvalid    = cpu_rvalid_q;
  assign cpu_rdata     = cpu_rvalid_q ? mem_rdata : '0;
  assign MonDReg       = mon_dreg_q;
  assign monitor_ready = monitor_ready_q;
  assign monitor_error = monitor_error_q;

endmodule

// File: tb/tb_nios_system_tec2_cpu_cpu_ocimem_arbiter.sv
module tb_nios_system_tec2_cpu_cpu_ocimem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam logic [31:0] CpuRdVal = 32'hCAFEF00D;  // RAM[0x12], the CPU read address

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [37:0]   jdo = '0;
  logic          take_a = 1'b0, take_b = 1'b0, take_na = 1'b0;
  logic          debugack = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [31:0]   MonDReg;
  logic          monitor_ready, monitor_error, jtag_busy;

  int n_asserts = 0;
  int n_fail = 0;

  logic [31:0] jtag_q[$];
  logic [31:0] cpu_q[$];
  int cpu_rd_ok = 0, cpu_rd_bad = 0, gnt_cnt = 0, access_cnt = 0;
  logic overlap_seen = 1'b0;

  logic [DW-1:0] ram [256];

  always #5 clk = ~clk;

  nios_system_tec2_cpu_cpu_ocimem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_na),
    .debugack                (debugack),
    .cpu_req                 (cpu_req),
    .cpu_we                  (cpu_we),
    .cpu_addr                (cpu_addr),
    .cpu_wdata               (cpu_wdata),
    .cpu_gnt                 (cpu_gnt),
    .cpu_rvalid              (cpu_rvalid),
    .cpu_rdata               (cpu_rdata),
    .mem_addr                (mem_addr),
    .mem_we                  (mem_we),
    .mem_re                  (mem_re),
    .mem_wdata               (mem_wdata),
    .mem_rdata               (mem_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .jtag_busy               (jtag_busy)
  );

  // Synchronous RAM model, preloaded while reset is held
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      ram[8'h12] <= 32'hCAFEF00D;
      ram[8'h00] <= 32'h55AA55AA;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
    end
  end

  // CPU-side scoreboard and bus monitors
  always @(negedge clk) begin
    if (mem_we && mem_re) overlap_seen <= 1'b1;
    if (mem_we || mem_re) access_cnt <= access_cnt + 1;
    if (cpu_gnt) gnt_cnt <= gnt_cnt + 1;
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) cpu_rd_bad <= cpu_rd_bad + 1;
      else if (cpu_rdata === cpu_q.pop_front()) cpu_rd_ok <= cpu_rd_ok + 1;
      else cpu_rd_bad <= cpu_rd_bad + 1;
    end
    if (cpu_gnt && !cpu_we) cpu_q.push_back(CpuRdVal);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_a(input logic [7:0] addr, input logic rd);
    jdo = '0;
    jdo[35] = rd;
    jdo[17:10] = addr;
    take_a = 1'b1;
    tick();
    take_a = 1'b0;
  endtask

  task automatic strobe_b(input logic [31:0] data);
    jdo = '0;
    jdo[34:3] = data;
    take_b = 1'b1;
    tick();
    take_b = 1'b0;
  endtask

  task automatic strobe_na();
    jdo = '0;
    take_na = 1'b1;
    tick();
    take_na = 1'b0;
  endtask

  task automatic wait_ready(input int max_cyc, input string tag);
    int lat;
    lat = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      if (monitor_ready) begin
        lat = i;
        break;
      end
    end
    check({tag, "_ready"}, 64'(lat != 0), 64'd1);
  endtask

  task automatic wait_read(input int max_cyc, input string tag);
    logic [31:0] exp;
    wait_ready(max_cyc, tag);
    exp = (jtag_q.size() != 0) ? jtag_q.pop_front() : 32'hx;
    check({tag, "_mondreg"}, 64'(MonDReg), 64'(exp));
  endtask

  initial begin
    int g0, a0, rdy_seen;
    logic seen;

    // Reset state
    #3;
    check("rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
    check("rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
    check("rst_mem_we_re", 64'({mem_we, mem_re}), 64'd0);
    check("rst_ready_err_busy", 64'({monitor_ready, monitor_error, jtag_busy}), 64'd0);
    check("rst_mondreg", 64'(MonDReg), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    debugack = 1'b1;
    tick();
    tick();

    // JTAG read of 0x12 from idle
    jtag_q.push_back(32'hCAFEF00D);
    strobe_a(8'h12, 1'b1);
    wait_read(4, "rd_12");
    check("rd_12_busy_clear", 64'(jtag_busy), 64'd0);
    check("rd_12_err_clear", 64'(monitor_error), 64'd0);

    // Address 0xFF, write, wrap to 0x00
    strobe_a(8'hFF, 1'b0);
    check("addr_only_busy", 64'(jtag_busy), 64'd0);
    strobe_b(32'h1);
    wait_ready(5, "wr_ff");
    check("wr_ff_ram", 64'(ram[8'hFF]), 64'd1);
    jtag_q.push_back(32'h55AA55AA);
    strobe_na();
    wait_read(4, "wrap_rd_00");

    // Write two words then read back; ocimem_a read does not advance
    strobe_a(8'h40, 1'b0);
    strobe_b(32'h12345678);
    wait_ready(5, "wr_40");
    strobe_b(32'h9ABCDEF0);
    wait_ready(5, "wr_41");
    jtag_q.push_back(32'h12345678);
    strobe_a(8'h40, 1'b1);
    wait_read(4, "rd_40_a");
    jtag_q.push_back(32'h12345678);
    strobe_na();
    wait_read(4, "rd_40_na");
    jtag_q.push_back(32'h9ABCDEF0);
    strobe_na();
    wait_read(4, "rd_41_na");

    // Continuous CPU reads contending with JTAG reads
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 8'h12;
    tick();
    tick();
    tick();
    g0 = gnt_cnt;
    jtag_q.push_back(32'h9ABCDEF0);
    strobe_a(8'h41, 1'b1);
    wait_read(5, "cont_rd_41_a");
    jtag_q.push_back(32'h9ABCDEF0);
    strobe_na();
    wait_read(5, "cont_rd_41_na");
    check("cont_cpu_grants", 64'((gnt_cnt - g0) >= 2), 64'd1);
    cpu_req = 1'b0;
    tick();
    tick();
    tick();

    // CPU write
    cpu_we = 1'b1;
    cpu_addr = 8'h30;
    cpu_wdata = 32'hDEADBEEF;
    cpu_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_gnt) begin
        seen = 1'b1;
        break;
      end
    end
    check("cpu_wr_gnt", 64'(seen), 64'd1);
    cpu_req = 1'b0;
    tick();
    check("cpu_wr_ram", 64'(ram[8'h30]), 64'hDEADBEEF);
    cpu_we = 1'b0;
    tick();

    // Strobe while busy is dropped; first command still completes
    jtag_q.push_back(32'h12345678);
    strobe_a(8'h40, 1'b1);
    strobe_b(32'h00000BAD);
    check("busy_drop_err", 64'(monitor_error), 64'd1);
    wait_read(4, "busy_first_rd");
    check("busy_err_sticky", 64'(monitor_error), 64'd1);
    check("busy_ram_intact", 64'(ram[8'h40]), 64'h12345678);
    jtag_q.push_back(32'h12345678);
    strobe_na();
    check("accept_clears_err", 64'(monitor_error), 64'd0);
    wait_read(4, "busy_addr_unchanged");

    // Strobe with debugack low
    debugack = 1'b0;
    a0 = access_cnt;
    strobe_na();
    check("noack_err", 64'(monitor_error), 64'd1);
    check("noack_busy", 64'(jtag_busy), 64'd0);
    tick();
    tick();
    tick();
    check("noack_no_access", 64'(access_cnt), 64'(a0));
    debugack = 1'b1;

    // debugack falls while a command is pending
    a0 = access_cnt;
    strobe_na();
    debugack = 1'b0;
    tick();
    check("ackfall_err", 64'(monitor_error), 64'd1);
    check("ackfall_busy", 64'(jtag_busy), 64'd0);
    tick();
    tick();
    check("ackfall_no_access", 64'(access_cnt), 64'(a0));
    check("ackfall_no_ready", 64'(monitor_ready), 64'd0);
    debugack = 1'b1;
    jtag_q.push_back(32'hCAFEF00D);
    strobe_a(8'h12, 1'b1);
    wait_read(4, "recover_rd_12");

    // Reset pulse while in RD_WAIT
    strobe_a(8'h12, 1'b1);
    check("midrst_busy", 64'(jtag_busy), 64'd1);
    tick();
    check("midrst_mem_re", 64'(mem_re), 64'd1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_ready_err_busy", 64'({monitor_ready, monitor_error, jtag_busy}), 64'd0);
    check("midrst_mondreg", 64'(MonDReg), 64'd0);
    check("midrst_bus", 64'({cpu_gnt, cpu_rvalid, mem_we, mem_re}), 64'd0);
    #2;
    reset_n = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (monitor_ready || jtag_busy) rdy_seen++;
    end
    check("midrst_no_completion", 64'(rdy_seen), 64'd0);

    // End-of-run scoreboard state
    check("cpu_rd_bad", 64'(cpu_rd_bad), 64'd0);
    check("cpu_rd_some", 64'(cpu_rd_ok >= 2), 64'd1);
    check("we_re_overlap", 64'(overlap_seen), 64'd0);
    check("jtag_q_empty", 64'(jtag_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
